// File: rtl/cpu_wb_pkg.sv
// Shared definitions for the write-back sequencer and the register blocks it drives:
// access codes, phase numbers and the sequencer state encoding.
package cpu_wb_pkg;

  localparam logic [3:0] NOP_CODE = 4'h0;

  // ebx select codes as they appear on slot A and slot B of the bus
  localparam logic [3:0] REG_EBX_A = 4'h6;
  localparam logic [3:0] REG_EBX_B = 4'h7;

  localparam logic [2:0] PH_SLOT_A     = 3'd4;
  localparam logic [2:0] PH_SLOT_B     = 3'd6;
  localparam logic [2:0] PH_LAST       = 3'd7;
  localparam logic [2:0] PH_LAST_SHORT = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/writeback_sequencer_if.sv
// Request/operand inputs and register-bus outputs of the write-back sequencer.
interface writeback_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic [3:0]        code_a;
  logic [DATA_W-1:0] data_a;
  logic [3:0]        code_b;
  logic [DATA_W-1:0] data_b;
  logic              ready;
  logic [2:0]        phase;
  logic              phase_4;
  logic              phase_6;
  logic [3:0]        read_or_write;
  logic [DATA_W-1:0] write_data;
  logic              done;

  modport master (
    output req, code_a, data_a, code_b, data_b,
    input  ready, phase, phase_4, phase_6, read_or_write, write_data, done
  );

  modport slave (
    input  req, code_a, data_a, code_b, data_b,
    output ready, phase, phase_4, phase_6, read_or_write, write_data, done
  );
endinterface

// File: rtl/writeback_sequencer_phase_counter.sv
// 3-bit phase counter with clear/enable and a compare against the run's terminal phase.
module phase_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [2:0] last,
  output logic [2:0] count,
  output logic       at_last
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 3'd1;
    end
  end

  assign at_last = (count == last);

endmodule

// File: rtl/writeback_sequencer.sv
// Steps one accepted write-back request through phases 0..7 and presents slot A
// (phases 4-5) and slot B (phases 6-7) on the shared register bus.
module writeback_sequencer
  import cpu_wb_pkg::state_e, cpu_wb_pkg::IDLE, cpu_wb_pkg::RUN,
         cpu_wb_pkg::PH_SLOT_A, cpu_wb_pkg::PH_SLOT_B,
         cpu_wb_pkg::PH_LAST, cpu_wb_pkg::PH_LAST_SHORT;
#(
  parameter int         DATA_W   = 32,
  parameter logic [3:0] NOP_CODE = cpu_wb_pkg::NOP_CODE
) (
  input  logic                  clock,
  input  logic                  reset,
  writeback_sequencer_if.slave  bus
);

  state_e            state, state_next;
  logic [3:0]        cap_code_a, cap_code_b;
  logic [DATA_W-1:0] cap_data_a, cap_data_b;
  logic [2:0]        count;
  logic [2:0]        last_phase;
  logic              at_last;
  logic              running;

  assign running    = (state == RUN);
  // An empty slot B ends the run right after slot A
  assign last_phase = (cap_code_b == NOP_CODE) ? PH_LAST_SHORT : PH_LAST;

  phase_counter u_phase_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (running && at_last),
    .enable  (running),
    .last    (last_phase),
    .count   (count),
    .at_last (at_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb assigns its outputs a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.req) state_next = RUN;
      RUN:  if (at_last) state_next = IDLE;
    endcase
  end

  // NOTE: operand registers are reset so an aborted run can never leak onto the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_code_a <= NOP_CODE;
      cap_data_a <= '0;
      cap_code_b <= NOP_CODE;
      cap_data_b <= '0;
    end else if ((state == IDLE) && bus.req) begin
      cap_code_a <= bus.code_a;
      cap_data_a <= bus.data_a;
      cap_code_b <= bus.code_b;
      cap_data_b <= bus.data_b;
    end
  end

  always_comb begin
    bus.ready         = (state == IDLE);
    bus.phase         = count;
    bus.phase_4       = 1'b0;
    bus.phase_6       = 1'b0;
    bus.done          = 1'b0;
    bus.read_or_write = NOP_CODE;
    bus.write_data    = '0;
    if (running) begin
      bus.phase_4 = (count == PH_SLOT_A);
      bus.phase_6 = (count == PH_SLOT_B);
      bus.done    = at_last;
      if (count >= PH_SLOT_B) begin
        bus.read_or_write = cap_code_b;
        bus.write_data    = cap_data_b;
      end else if (count >= PH_SLOT_A) begin
        bus.read_or_write = cap_code_a;
        bus.write_data    = cap_data_a;
      end
    end
  end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Randomized and directed bench for writeback_sequencer with a queue-based scoreboard.
module tb_writeback_sequencer;
  import cpu_wb_pkg::*;

  localparam int EV_P4   = 0;
  localparam int EV_P6   = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          at;
    int          kind;
    logic [3:0]  code;
    logic [31:0] data;
  } ev_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  writeback_sequencer_if #(.DATA_W(32)) bus ();

  writeback_sequencer #(.DATA_W(32), .NOP_CODE(4'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_from = 0;

  ev_t         evq[$];
  bit          job_valid = 1'b0;
  int          job_t = 0;
  int          job_last = 0;
  logic [3:0]  job_ca, job_cb;
  logic [31:0] job_da, job_db;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic push_ev(input int at, input int kind, input logic [3:0] code, input logic [31:0] data);
    ev_t e;
    e.at = at; e.kind = kind; e.code = code; e.data = data;
    evq.push_back(e);
  endtask

  // Reference model: a request is taken whenever the model says the sequencer is free.
  always @(posedge clock) begin
    if (!reset && bus.req && cyc >= free_from) begin
      job_valid = 1'b1;
      job_t     = cyc;
      job_ca    = bus.code_a;
      job_da    = bus.data_a;
      job_cb    = bus.code_b;
      job_db    = bus.data_b;
      job_last  = (bus.code_b == NOP_CODE) ? 5 : 7;
      push_ev(cyc + 5, EV_P4, bus.code_a, bus.data_a);
      if (bus.code_b != NOP_CODE) begin
        push_ev(cyc + 7, EV_P6, bus.code_b, bus.data_b);
        push_ev(cyc + 8, EV_DONE, bus.code_b, bus.data_b);
      end else begin
        push_ev(cyc + 6, EV_DONE, bus.code_a, bus.data_a);
      end
      free_from = cyc + job_last + 2;
    end
    cyc++;
  end

  task automatic match_event(input int kind);
    ev_t e;
    if (evq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe at cycle %0d: got kind %0d, expected none", cyc, kind);
    end else begin
      e = evq.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.at);
      check("event_code", bus.read_or_write, e.code);
      check("event_data", bus.write_data, e.data);
    end
  endtask

  // Monitor: per-cycle handshake/phase/bus compare plus strobe scoreboard.
  always @(negedge clock) begin : monitor
    int          ph;
    logic [3:0]  erw;
    logic [31:0] ewd;
    if (!reset) begin
      check("ready", bus.ready, cyc >= free_from);
      ph = (job_valid && cyc > job_t && cyc <= job_t + 1 + job_last) ? cyc - job_t - 1 : -1;
      check("phase", bus.phase, (ph < 0) ? 0 : ph);
      erw = NOP_CODE;
      ewd = '0;
      if (ph >= 6) begin
        erw = job_cb; ewd = job_db;
      end else if (ph >= 4) begin
        erw = job_ca; ewd = job_da;
      end
      check("read_or_write", bus.read_or_write, erw);
      check("write_data", bus.write_data, ewd);
      while (evq.size() > 0 && evq[0].at < cyc) begin
        check("missed_event_cycle", cyc, evq[0].at);
        void'(evq.pop_front());
      end
      if (bus.phase_4) match_event(EV_P4);
      if (bus.phase_6) match_event(EV_P6);
      if (bus.done)    match_event(EV_DONE);
    end
  end

  task automatic check_reset_values();
    check("rst_ready", bus.ready, 1'b1);
    check("rst_phase", bus.phase, 3'd0);
    check("rst_phase_4", bus.phase_4, 1'b0);
    check("rst_phase_6", bus.phase_6, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_read_or_write", bus.read_or_write, NOP_CODE);
    check("rst_write_data", bus.write_data, 32'h0);
  endtask

  // Called at a falling edge; asserts reset away from both edges.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    evq.delete();
    job_valid = 1'b0;
    free_from = 0;
    #1 check_reset_values();
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc < free_from) @(negedge clock);
  endtask

  task automatic issue(input logic [3:0] ca, input logic [31:0] da,
                       input logic [3:0] cb, input logic [31:0] db, output int t);
    wait_free();
    t = cyc;
    bus.req = 1'b1; bus.code_a = ca; bus.data_a = da; bus.code_b = cb; bus.data_b = db;
    @(negedge clock);
    bus.req = 1'b0;
  endtask

  task automatic drive_random();
    bus.code_a = 4'($urandom_range(0, 15));
    bus.data_a = $urandom;
    bus.code_b = ($urandom_range(0, 3) == 0) ? NOP_CODE : 4'($urandom_range(1, 15));
    bus.data_b = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset = 1'b1;
    bus.req = 1'b0; bus.code_a = NOP_CODE; bus.data_a = '0; bus.code_b = NOP_CODE; bus.data_b = '0;
    #2 check_reset_values();
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);

    // Full request, then mid-run input changes and a rejected request while busy
    issue(REG_EBX_A, 32'h0000_1234, REG_EBX_B, 32'hDEAD_BEEF, t);
    @(negedge clock);
    bus.data_a = 32'hBAD0_BAD0;
    @(negedge clock);
    bus.req = 1'b1; bus.code_a = 4'h3; bus.data_a = 32'h5555_AAAA;
    bus.code_b = 4'h9; bus.data_b = 32'h1111_2222;
    @(negedge clock);
    bus.req = 1'b0;

    // Early finish
    issue(REG_EBX_A, 32'h888, NOP_CODE, 32'hFFFF_0000, t);

    // Empty slot A still occupies its phases
    issue(NOP_CODE, 32'h0000_00A5, REG_EBX_B, 32'h0000_005A, t);

    // Reset during phase 5 of a full request, then idle with no strobes
    issue(REG_EBX_A, 32'hCAFE_0001, REG_EBX_B, 32'hCAFE_0002, t);
    while (cyc < t + 6) @(negedge clock);
    pulse_reset();
    repeat (12) @(negedge clock);

    // Back-to-back: request held high with operands changing every cycle
    wait_free();
    for (int i = 0; i < 20; i++) begin
      bus.req = 1'b1;
      drive_random();
      @(negedge clock);
    end
    bus.req = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.req = ($urandom_range(0, 2) == 0);
      drive_random();
      @(negedge clock);
    end
    bus.req = 1'b0;
    repeat (12) @(negedge clock);

    check("pending_events", evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_sequencer.md
# writeback_sequencer

Single-clock sequencer that sits directly upstream of the architectural register blocks (eax/ebx/… registers) and drives their shared `read_or_write` / `write_data` bus. It accepts one write-back request from the decode/execute logic, steps through an 8-phase instruction cycle, and presents up to two register writes: slot A at phase 4 and slot B at phase 6. It also emits single-cycle `phase_4` / `phase_6` strobes that register blocks use as write enables.

## Interface
- `DATA_W`, 32, width of write data.
- `NOP_CODE`, 4'h0, `read_or_write` value meaning "no register access".

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  write-back request; accepted only when `ready`=1.
- `code_a`  in  4  slot-A register select code (e.g. 4'h6 = ebx), sampled on accept.
- `data_a`  in  DATA_W  slot-A write value, sampled on accept.
- `code_b`  in  4  slot-B register select code (e.g. 4'h7 = ebx), sampled on accept.
- `data_b`  in  DATA_W  slot-B write value, sampled on accept.
- `ready`  out  1  high only in IDLE.
- `phase`  out  3  current phase 0..7 (0 while idle).
- `phase_4`  out  1  one-cycle strobe in phase 4.
- `phase_6`  out  1  one-cycle strobe in phase 6.
- `read_or_write`  out  4  register access code to register blocks.
- `write_data`  out  DATA_W  data to register blocks.
- `done`  out  1  one-cycle pulse in the last active phase.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: `ready`=1, `phase`=0. If `req`=1: capture `code_a`, `data_a`, `code_b`, `data_b` and go to RUN with `phase`=0.
- RUN: `phase` increments by 1 each cycle.
- Phases 0–3: `read_or_write`=NOP_CODE, `write_data`=0.
- Phases 4–5: `read_or_write`=captured `code_a`, `write_data`=captured `data_a`. `phase_4`=1 in phase 4 only.
- Phases 6–7: `read_or_write`=captured `code_b`, `write_data`=captured `data_b`. `phase_6`=1 in phase 6 only.
- Last phase is 7. `done`=1 in that cycle, and the next state is IDLE.
- Early finish: if captured `code_b`==NOP_CODE, the last phase is 5. `done`=1 in phase 5, then IDLE. Phases 6–7 and `phase_6` do not occur.
- `code_a`==NOP_CODE: slot A still occupies phases 4–5 and `phase_4` still pulses. Bus shows NOP_CODE with `data_a`, and consumers ignore it.
- `req` while `ready`=0 is ignored and not queued. Inputs are sampled only on the accepting edge, so later input changes have no effect.
- Reset values, applied asynchronously at any time including mid-RUN: state IDLE, `ready`=1, `phase`=0, `phase_4`=0, `phase_6`=0, `done`=0, `read_or_write`=NOP_CODE, `write_data`=0. Captured operands are discarded and no partial write is replayed.
- Outputs are decoded from registered state only. No combinational path from inputs to outputs.

## Timing
- Accept edge at cycle T (IDLE, `req`=1) → phase 0 at T+1, phase k at T+1+k.
- `phase_4` at T+5, `phase_6` at T+7, `done` at T+8, `ready` back at T+9.
- Early finish: `done` at T+6, `ready` at T+7.
- Minimum issue interval: 9 cycles full, 7 cycles early finish. A `req` held high continuously is accepted on the first `ready` cycle.
- Bus value is stable for both cycles of each slot, so a consumer may write on the strobe cycle.

## Structure
- Shared package `cpu_wb_pkg` holds:
  - `NOP_CODE`
  - phase constants `PH_SLOT_A`=4, `PH_SLOT_B`=6, `PH_LAST`=7, `PH_LAST_SHORT`=5
  - state encoding IDLE/RUN
  - register select codes used by register blocks (4'h6, 4'h7, …)
- One sub-module: `phase_counter`, a 3-bit counter with clear and enable plus terminal-phase compare. The sequencer FSM, operand capture and output mux live in the top.

## Test plan
- Reset mid-RUN: assert `reset` during phase 5 → all outputs immediately at reset values. After release, `ready`=1, `phase`=0, and no further strobes occur.
- Full request: `req` with code_a=4'h6, data_a=32'h0000_1234, code_b=4'h7, data_b=32'hDEAD_BEEF.
  - Required bus: 4'h6/1234 at T+5..T+6, 4'h7/DEADBEEF at T+7..T+8.
  - Required strobes and handshake: `phase_4` at T+5, `phase_6` at T+7, `done` at T+8, `ready` at T+9.
- Early finish: code_b=NOP_CODE, code_a=4'h6, data_a=32'h888 → `done` at T+6, `ready` at T+7, `phase_6` never asserts.
- Busy rejection and input hold: pulse `req` with new operands at T+3, and change `data_a` at T+2 → both ignored, bus still shows the originally captured values.
- Back-to-back: `req` held high for 20 cycles → second accept at T+9. Bus for the second request matches its captured operands, with no NOP gap beyond phases 0–3.
